matrix_key_scan: RTL and testbench



---
 rtl/board_test_pkg.sv | 29 ++
 rtl/key_debounce.sv | 61 ++++++
 rtl/matrix_key_scan.sv | 216 +++++++++++++++++++++
 tb/tb_matrix_key_scan.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_test_pkg.sv
// Shared types and helpers for the board-test input blocks: key FSM encoding,
// default scan timing and the lowest-set-bit priority encoder.
package board_test_pkg;

    typedef enum logic [0:0] {
        IDLE_UP = 1'b0,
        DOWN    = 1'b1
    } key_fsm_e;

    localparam int unsigned DEF_SCAN_DIV       = 1000;
    localparam int unsigned DEF_DEBOUNCE_SCANS = 8;
    localparam int unsigned DEF_REPEAT_DELAY   = 32;
    localparam int unsigned DEF_REPEAT_SCANS   = 8;

    // Widest matrix supported (8 x 8); callers zero-extend into this width.
    localparam int unsigned MAX_KEYS = 64;

    function automatic logic [5:0] lowest_set(input logic [MAX_KEYS-1:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int unsigned i = MAX_KEYS; i > 0; i--) begin
            if (v[i-1]) begin
                idx = 6'(i - 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Whole-matrix debouncer: commits a snapshot once it has been seen on
// DEBOUNCE_SCANS consecutive identical full scans; commit_o is a registered strobe.
module key_debounce
    import board_test_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] snap_i,
    input  logic             scan_end_i,
    output logic [WIDTH-1:0] state_o,
    output logic             commit_o
);

    localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             commit_q, commit_d;

    always_comb begin
        stable_cnt_d = stable_cnt_q;
        prev_d       = prev_q;
        state_d      = state_q;
        commit_d     = 1'b0;
        if (scan_end_i) begin
            prev_d = snap_i;
            if (snap_i != prev_q) begin
                stable_cnt_d = '0;
            end else if (stable_cnt_q != CNT_MAX) begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end
            if ((stable_cnt_d == CNT_MAX) && (snap_i != state_q)) begin
                state_d  = snap_i;
                commit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable_cnt_q <= '0;
            prev_q       <= '0;
            state_q      <= '0;
            commit_q     <= 1'b0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            commit_q     <= commit_d;
        end
    end

    assign state_o  = state_q;
    assign commit_o = commit_q;

endmodule

// File: rtl/matrix_key_scan.sv
// Row/column key matrix scanner with debounce and press/release strobes.
// Optional auto-repeat of key_valid while held: define KEY_AUTOREPEAT_EN.
module matrix_key_scan
    import board_test_pkg::*;
#(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned CODE_W         = 4,
    parameter int unsigned SCAN_DIV       = DEF_SCAN_DIV,
    parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_SCANS   = DEF_REPEAT_SCANS
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [COLS-1:0]   key_col,
    input  logic [ROWS-1:0]   key_row,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              key_multi
);

    localparam int unsigned KEYS   = ROWS * COLS;
    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned CIDX_W = $clog2(COLS);

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || (2 ** CODE_W) < KEYS ||
        SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_DELAY < 1 ||
        REPEAT_SCANS < 1 || REPEAT_SCANS > REPEAT_DELAY) begin : g_bad_cfg
        $error("matrix_key_scan: illegal parameter set");
    end

    logic [ROWS-1:0]   row_s1_q, row_s1_d;
    logic [ROWS-1:0]   row_s2_q, row_s2_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [CIDX_W-1:0] col_idx_q, col_idx_d;
    logic [COLS-1:0]   key_col_q, key_col_d;
    logic [KEYS-1:0]   snap_q, snap_d;
    logic              col_end;
    logic              scan_end;

    key_fsm_e          fsm_q, fsm_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_release_q, key_release_d;
    logic              key_held_q, key_held_d;
    logic              key_multi_q, key_multi_d;

    logic [KEYS-1:0]     deb_state;
    logic                deb_commit;
    logic [MAX_KEYS-1:0] deb_wide;
    logic                deb_nonzero;
    logic                deb_multi;
    logic [CODE_W-1:0]   deb_code;

    // Column scanner: key_col follows col_idx one cycle late, so each column is
    // driven for SCAN_DIV cycles and sampled on its last one.
    always_comb begin
        row_s1_d  = key_row;
        row_s2_d  = row_s1_q;
        div_cnt_d = div_cnt_q;
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        for (int unsigned c = 0; c < COLS; c++) begin
            key_col_d[c] = (col_idx_q != CIDX_W'(c));
        end
        col_end  = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
        scan_end = col_end && (col_idx_q == CIDX_W'(COLS - 1));
        if (col_end) begin
            div_cnt_d = '0;
            col_idx_d = scan_end ? '0 : col_idx_q + 1'b1;
            for (int unsigned c = 0; c < COLS; c++) begin
                if (col_idx_q == CIDX_W'(c)) begin
                    snap_d[c*ROWS +: ROWS] = ~row_s2_q;
                end
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_s1_q  <= '1;
            row_s2_q  <= '1;
            div_cnt_q <= '0;
            col_idx_q <= '0;
            key_col_q <= '1;
            snap_q    <= '0;
        end else begin
            row_s1_q  <= row_s1_d;
            row_s2_q  <= row_s2_d;
            div_cnt_q <= div_cnt_d;
            col_idx_q <= col_idx_d;
            key_col_q <= key_col_d;
            snap_q    <= snap_d;
        end
    end

    key_debounce #(
        .WIDTH          (KEYS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rstn       (rstn),
        .snap_i     (snap_d),
        .scan_end_i (scan_end),
        .state_o    (deb_state),
        .commit_o   (deb_commit)
    );

    always_comb begin
        deb_wide            = '0;
        deb_wide[KEYS-1:0]  = deb_state;
        deb_nonzero         = |deb_state;
        deb_multi           = |(deb_state & (deb_state - 1'b1));
        deb_code            = CODE_W'(lowest_set(deb_wide));
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             scan_end_q, scan_end_d;
`endif

    always_comb begin
        fsm_d         = fsm_q;
        key_code_d    = key_code_q;
        key_held_d    = key_held_q;
        key_multi_d   = key_multi_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        if (deb_commit) begin
            key_held_d  = deb_nonzero;
            key_multi_d = deb_multi;
            if (deb_nonzero) begin
                key_code_d = deb_code;
            end
        end
        unique case (fsm_q)
            IDLE_UP: begin
                if (deb_commit && deb_nonzero) begin
                    key_valid_d = 1'b1;
                    fsm_d       = DOWN;
                end
            end
            DOWN: begin
                if (deb_commit) begin
                    if (!deb_nonzero) begin
                        key_release_d = 1'b1;
                        fsm_d         = IDLE_UP;
                    end else if (deb_code != key_code_q) begin
                        key_valid_d = 1'b1;
                    end
                end
            end
            default: fsm_d = IDLE_UP;
        endcase
`ifdef KEY_AUTOREPEAT_EN
        // Scan end is delayed a cycle so it lines up with the registered commit,
        // letting a commit take priority over a repeat on the same edge.
        scan_end_d = scan_end;
        rpt_cnt_d  = rpt_cnt_q;
        if ((fsm_q != DOWN) || deb_commit) begin
            rpt_cnt_d = '0;
        end else if (scan_end_q) begin
            if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                key_valid_d = 1'b1;
                rpt_cnt_d   = RPT_W'(REPEAT_DELAY - REPEAT_SCANS);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q         <= IDLE_UP;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_held_q    <= 1'b0;
            key_multi_q   <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            key_held_q    <= key_held_d;
            key_multi_q   <= key_multi_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpt_cnt_q  <= '0;
            scan_end_q <= 1'b0;
        end else begin
            rpt_cnt_q  <= rpt_cnt_d;
            scan_end_q <= scan_end_d;
        end
    end
`endif

    assign key_col     = key_col_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_held    = key_held_q;
    assign key_multi   = key_multi_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Directed bench for matrix_key_scan: 4x4 matrix, SCAN_DIV=4, DEBOUNCE_SCANS=3.
// With KEY_AUTOREPEAT_EN defined the auto-repeat timing scenario replaces the press scenarios.
module tb_matrix_key_scan;

    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 4;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned DEB       = 3;
    localparam int unsigned RPT_DELAY = 4;
    localparam int unsigned RPT_SCANS = 2;
    localparam int unsigned SCAN      = COLS * SCAN_DIV;
    localparam int unsigned BUDGET    = (DEB + 1) * SCAN + 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic [COLS-1:0]   key_col;
    logic [ROWS-1:0]   key_row;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_release;
    logic              key_held;
    logic              key_multi;
    logic [15:0]       pressed;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned n_valid    = 0;
    int unsigned n_release  = 0;
    int unsigned n_both     = 0;
    longint      cyc        = 0;
    longint      vq[$];

    matrix_key_scan #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .CODE_W         (CODE_W),
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_DELAY   (RPT_DELAY),
        .REPEAT_SCANS   (RPT_SCANS)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_col     (key_col),
        .key_row     (key_row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_held    (key_held),
        .key_multi   (key_multi)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        key_row = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (pressed[c*ROWS + r] && !key_col[c]) key_row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (key_valid) begin
            n_valid = n_valid + 1;
            vq.push_back(cyc);
        end
        if (key_release) n_release = n_release + 1;
        if (key_valid && key_release) n_both = n_both + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input bit rel, input int unsigned budget, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (rel ? key_release : key_valid) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           seen;
        int unsigned  bv, br;
        logic [3:0]   exp_col;

        rstn    = 1'b0;
        pressed = '0;
        idle(3);
        check_eq("rst_col", key_col, 4'hF);
        check_eq("rst_code", key_code, 0);
        check_eq("rst_valid", key_valid, 0);
        check_eq("rst_release", key_release, 0);
        check_eq("rst_held", key_held, 0);
        check_eq("rst_multi", key_multi, 0);

        // Column walk, then 20 idle scans with no strobes.
        rstn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            check_eq($sformatf("walk%0d", i), key_col, exp_col);
        end
        idle(20 * SCAN);
        check_eq("idle_valid_cnt", n_valid, 0);
        check_eq("idle_release_cnt", n_release, 0);

`ifndef KEY_AUTOREPEAT_EN
        // Single key 9 (col 2, row 1): press and release.
        bv = n_valid; br = n_release;
        pressed[9] = 1'b1;
        wait_strobe(1'b0, BUDGET, seen);
        check_eq("k9_press_seen", seen, 1);
        check_eq("k9_code", key_code, 9);
        check_eq("k9_held", key_held, 1);
        check_eq("k9_multi", key_multi, 0);
        idle(3 * SCAN);
        check_eq("k9_one_valid", n_valid - bv, 1);
        pressed[9] = 1'b0;
        wait_strobe(1'b1, BUDGET, seen);
        check_eq("k9_release_seen", seen, 1);
        check_eq("k9_rel_held", key_held, 0);
        check_eq("k9_rel_code", key_code, 9);
        idle(SCAN);
        check_eq("k9_release_cnt", n_release - br, 1);
        check_eq("k9_valid_cnt", n_valid - bv, 1);

        // Bounce: key 9 flips every scan, never stable long enough to commit.
        bv = n_valid; br = n_release;
        for (int k = 0; k < 10; k++) begin
            pressed[9] = ~pressed[9];
            idle(SCAN);
        end
        idle(6 * SCAN);
        check_eq("bounce_valid_cnt", n_valid - bv, 0);
        check_eq("bounce_release_cnt", n_release - br, 0);
        check_eq("bounce_held", key_held, 0);

        // Keys 4 and 9 together, then release key 4 only.
        bv = n_valid; br = n_release;
        pressed = 16'h0210;
        wait_strobe(1'b0, BUDGET, seen);
        check_eq("dual_press_seen", seen, 1);
        check_eq("dual_code", key_code, 4);
        check_eq("dual_multi", key_multi, 1);
        check_eq("dual_held", key_held, 1);
        idle(4 * SCAN);
        check_eq("dual_one_valid", n_valid - bv, 1);
        pressed = 16'h0200;
        wait_strobe(1'b0, BUDGET, seen);
        check_eq("drop4_seen", seen, 1);
        check_eq("drop4_code", key_code, 9);
        check_eq("drop4_multi", key_multi, 0);
        check_eq("drop4_held", key_held, 1);
        idle(SCAN);
        check_eq("drop4_valid_cnt", n_valid - bv, 2);
        pressed = '0;
        wait_strobe(1'b1, BUDGET, seen);
        check_eq("dual_release_seen", seen, 1);
        check_eq("dual_rel_held", key_held, 0);
        check_eq("dual_rel_multi", key_multi, 0);
        idle(SCAN);
        check_eq("dual_release_cnt", n_release - br, 1);
        check_eq("dual_valid_cnt", n_valid - bv, 2);

        // Reset mid-scan while a key is held, then a fresh press after reset.
        pressed[9] = 1'b1;
        wait_strobe(1'b0, BUDGET, seen);
        check_eq("mid_press_seen", seen, 1);
        idle(5);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_col", key_col, 4'hF);
        check_eq("mid_rst_code", key_code, 0);
        check_eq("mid_rst_valid", key_valid, 0);
        check_eq("mid_rst_release", key_release, 0);
        check_eq("mid_rst_held", key_held, 0);
        check_eq("mid_rst_multi", key_multi, 0);
        idle(3);
        rstn = 1'b1;
        bv = n_valid; br = n_release;
        idle(2 * SCAN);
        check_eq("post_rst_quiet_valid", n_valid - bv, 0);
        check_eq("post_rst_quiet_release", n_release - br, 0);
        wait_strobe(1'b0, BUDGET, seen);
        check_eq("post_rst_press_seen", seen, 1);
        check_eq("post_rst_code", key_code, 9);
        check_eq("post_rst_held", key_held, 1);
        pressed = '0;
        wait_strobe(1'b1, BUDGET, seen);
        check_eq("post_rst_release_seen", seen, 1);
        check_eq("post_rst_rel_held", key_held, 0);
`else
        // Auto-repeat: key 0 held; repeats at 4, 6, 8, 10 scans after the press strobe.
        vq.delete();
        pressed[0] = 1'b1;
        wait_strobe(1'b0, BUDGET, seen);
        check_eq("rpt_press_seen", seen, 1);
        check_eq("rpt_code", key_code, 0);
        idle(165);
        pressed = '0;
        wait_strobe(1'b1, BUDGET, seen);
        check_eq("rpt_release_seen", seen, 1);
        for (int k = 1; k <= 4; k++) begin
            check_eq($sformatf("rpt_gap%0d", k),
                     (vq.size() > k) ? vq[k] - vq[0] : 0,
                     SCAN * (RPT_DELAY + (k - 1) * RPT_SCANS));
        end
`endif

        check_eq("no_valid_release_overlap", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
